lvl_cross_sampler: RTL and testbench

Level-crossing encoder that sits directly upstream of the FIR reconstruction subsystem. It takes a stream of signed 16-bit ADC samples and tracks which band of a uniform level grid the signal occupies. For every level crossing it emits one 16-bit event word {direction, timestamp}, which is the exact format consumed on the FIR subsystem's mm2st input. Its level indexing and reset level match the reconstruction stage, so both ends agree on the current level.

---
 rtl/lvl_cross_sampler.sv | 130 +++++++++++++
 tb/tb_lvl_cross_sampler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lvl_cross_sampler.sv
// Level-crossing encoder: tracks the band of a uniform level grid occupied by a
// signed 16-bit sample stream and emits one {direction, timestamp} word per level crossed.
`timescale 1ns/1ps
module lvl_cross_sampler #(
    parameter int unsigned LVLS_NUM        = 20,
    parameter int unsigned LVL_RESET_VALUE = 9,
    parameter logic [15:0] LVL_BASE        = 16'h8666,
    parameter logic [15:0] LVL_STEP        = 16'h0CCD
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] adc_data,
    input  logic        adc_valid,
    output logic        adc_ready,
    output logic [15:0] lc_data,
    output logic        lc_valid,
    input  logic        lc_ready,
    output logic [4:0]  curr_lvl
);

    localparam int BASE_I = int'($signed(LVL_BASE));
    localparam int STEP_I = int'(LVL_STEP);
    localparam logic signed [16:0] STEP_S  = 17'(STEP_I);
    localparam logic signed [16:0] RST_LO  = 17'(BASE_I + int'(LVL_RESET_VALUE) * STEP_I);
    localparam logic signed [16:0] RST_HI  = 17'(BASE_I + int'(LVL_RESET_VALUE + 1) * STEP_I);
    localparam logic [4:0]         TOP_LVL = 5'(LVLS_NUM - 1);
    localparam logic [4:0]         RST_LVL = 5'(LVL_RESET_VALUE);
    localparam logic [14:0]        TICK_MAX = 15'h7FFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_EMIT
    } state_t;

    state_t             state_q,  state_d;
    logic [15:0]        sample_q, sample_d;
    logic [14:0]        tick_q,   tick_d;
    logic [4:0]         lvl_q,    lvl_d;
    logic signed [16:0] lo_q,     lo_d;
    logic signed [16:0] hi_q,     hi_d;
    logic [15:0]        data_q,   data_d;
    logic               valid_q,  valid_d;

    logic signed [16:0] sample_ext;
    logic               cross_up;
    logic               cross_dn;

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            sample_q <= '0;
            tick_q   <= '0;
            lvl_q    <= RST_LVL;
            lo_q     <= RST_LO;
            hi_q     <= RST_HI;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            tick_q   <= tick_d;
            lvl_q    <= lvl_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        tick_d   = tick_q;
        lvl_d    = lvl_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        data_d   = data_q;
        valid_d  = valid_q;

        sample_ext = {sample_q[15], sample_q};
        cross_up   = (sample_ext >= hi_q) && (lvl_q < TOP_LVL);
        cross_dn   = (sample_ext < lo_q) && (lvl_q != 5'd0);

        case (state_q)
            S_IDLE: begin
                if (adc_valid) begin
                    sample_d = adc_data;
                    tick_d   = (tick_q == TICK_MAX) ? tick_q : tick_q + 15'd1;
                    state_d  = S_CMP;
                end
            end
            S_CMP, S_EMIT: begin
                // The handshake cycle re-checks the held sample against the already
                // stepped band, so a follow-on event is valid right after the handshake.
                if (state_q == S_CMP || lc_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    if (cross_up || cross_dn) begin
                        valid_d = 1'b1;
                        state_d = S_EMIT;
                        data_d  = {cross_up, tick_q};
                        tick_d  = '0;
                        if (cross_up) begin
                            lvl_d = lvl_q + 5'd1;
                            lo_d  = hi_q;
                            hi_d  = hi_q + STEP_S;
                        end else begin
                            lvl_d = lvl_q - 5'd1;
                            hi_d  = lo_q;
                            lo_d  = lo_q - STEP_S;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gated with reset_n so the block refuses samples for the whole reset interval.
    assign adc_ready = reset_n && (state_q == S_IDLE);
    assign lc_data   = data_q;
    assign lc_valid  = valid_q;
    assign curr_lvl  = lvl_q;

endmodule

// File: tb/tb_lvl_cross_sampler.sv
// Scoreboard bench for lvl_cross_sampler: stimulus pushes expected event words,
// a negedge monitor pops and compares them on every lc_valid/lc_ready handshake.
`timescale 1ns/1ps
module tb_lvl_cross_sampler;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic [15:0] adc_data  = '0;
    logic        adc_valid = 1'b0;
    logic        adc_ready;
    logic [15:0] lc_data;
    logic        lc_valid;
    logic        lc_ready  = 1'b1;
    logic [4:0]  curr_lvl;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];

    always #5 clock = ~clock;

    lvl_cross_sampler dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .adc_ready (adc_ready),
        .lc_data   (lc_data),
        .lc_valid  (lc_valid),
        .lc_ready  (lc_ready),
        .curr_lvl  (curr_lvl)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a handshake happens on the next rising edge whenever both are high here.
    always @(negedge clock) begin
        if (reset_n && lc_valid && lc_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_event: got %h expected none", lc_data);
            end else begin
                check("event", lc_data, exp_q.pop_front());
            end
        end
    end

    task automatic send_sample(input logic [15:0] v);
        int n = 0;
        @(negedge clock);
        adc_data  = v;
        adc_valid = 1'b1;
        while (!adc_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!adc_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got adc_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clock);
        #1 adc_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!adc_ready && n < 200);
        if (!adc_ready) begin
            total++;
            bad++;
            $display("FAIL %s_idle_timeout: got adc_ready=0 expected 1 within 200 cycles", name);
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        exp_q.delete();
        #2 reset_n = 1'b1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_adc_ready", 16'(adc_ready), 16'd0);
        check("rst_lc_valid",  16'(lc_valid),  16'd0);
        check("rst_lc_data",   lc_data,        16'h0000);
        check("rst_curr_lvl",  16'(curr_lvl),  16'd9);
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("rel_adc_ready", 16'(adc_ready), 16'd1);

        // Four quiet samples then an up crossing carrying timestamp 5
        exp_q.push_back(16'h8005);
        for (int i = 0; i < 4; i++) send_sample(16'd0);
        send_sample(16'd2000);
        wait_idle("t1");
        check("t1_curr_lvl", 16'(curr_lvl), 16'd10);
        check("t1_drain", 16'(exp_q.size()), 16'd0);

        // Back down with timestamp 1
        exp_q.push_back(16'h0001);
        send_sample(16'd0);
        wait_idle("t2");
        check("t2_curr_lvl", 16'(curr_lvl), 16'd9);
        check("t2_drain", 16'(exp_q.size()), 16'd0);

        // Two-level jump: second event carries timestamp 0
        do_reset();
        exp_q.push_back(16'h8001);
        exp_q.push_back(16'h8000);
        send_sample(16'd8000);
        wait_idle("t3");
        check("t3_curr_lvl", 16'(curr_lvl), 16'd11);
        check("t3_drain", 16'(exp_q.size()), 16'd0);

        // Backpressure: event held stable for 10 cycles
        do_reset();
        #1 lc_ready = 1'b0;
        send_sample(16'd2000);
        @(negedge clock);
        @(negedge clock);
        check("bp_latency_valid", 16'(lc_valid), 16'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_lc_data",   lc_data,        16'h8001);
            check("bp_adc_ready", 16'(adc_ready), 16'd0);
            check("bp_curr_lvl",  16'(curr_lvl),  16'd10);
            @(negedge clock);
        end
        exp_q.push_back(16'h8001);
        @(posedge clock);
        #1 lc_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("bp_ready_after_hs", 16'(adc_ready), 16'd1);
        check("bp_valid_after_hs", 16'(lc_valid),  16'd0);
        check("bp_drain", 16'(exp_q.size()), 16'd0);

        // Grid extremes: climb to the top, overshoot, fall to the bottom, undershoot
        do_reset();
        exp_q.push_back(16'h8001);
        for (int i = 0; i < 9; i++) exp_q.push_back(16'h8000);
        send_sample(16'h7FFF);
        wait_idle("top_climb");
        check("top_curr_lvl", 16'(curr_lvl), 16'd19);
        send_sample(16'h7FFF);
        wait_idle("top_over");
        check("top_over_curr_lvl", 16'(curr_lvl), 16'd19);
        check("top_drain", 16'(exp_q.size()), 16'd0);
        exp_q.push_back(16'h0002);
        for (int i = 0; i < 18; i++) exp_q.push_back(16'h0000);
        send_sample(16'h8000);
        wait_idle("bot_fall");
        check("bot_curr_lvl", 16'(curr_lvl), 16'd0);
        send_sample(16'h8000);
        wait_idle("bot_under");
        check("bot_under_curr_lvl", 16'(curr_lvl), 16'd0);
        check("bot_drain", 16'(exp_q.size()), 16'd0);

        // Saturated timestamp, then reset while the event is pending
        do_reset();
        for (int i = 0; i < 32800; i++) send_sample(16'd0);
        lc_ready = 1'b0;
        send_sample(16'd2000);
        @(negedge clock);
        @(negedge clock);
        check("sat_lc_valid", 16'(lc_valid), 16'd1);
        check("sat_lc_data",  lc_data,       16'hFFFF);
        check("sat_curr_lvl", 16'(curr_lvl), 16'd10);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_lc_valid",  16'(lc_valid),  16'd0);
        check("mid_rst_adc_ready", 16'(adc_ready), 16'd0);
        check("mid_rst_curr_lvl",  16'(curr_lvl),  16'd9);
        @(posedge clock);
        #2 reset_n = 1'b1;
        lc_ready = 1'b1;
        @(negedge clock);
        check("post_rst_adc_ready", 16'(adc_ready), 16'd1);
        check("final_drain", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
